colorspace_inv: RTL and testbench

//  Inverse colour-space converter: full-range BT.601 YCbCr 4:4:4 (12-bit) -> RGB (12-bit).

---
 rtl/colorspace_inv.sv | 108 ++++++++++
 tb/tb_colorspace_inv.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/colorspace_inv.sv
// rtl/colorspace_inv.sv - full-range BT.601 YCbCr 4:4:4 to RGB converter
// Three register stages (offset/multiply, sum/round, shift/clip) under one global enable.
module colorspace_inv #(
  parameter int DW   = 12,
  parameter int FRAC = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic          in_sof,
  input  logic          in_eol,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout0,
  output logic [DW-1:0] dout1,
  output logic [DW-1:0] dout2,
  output logic          out_sof,
  output logic          out_eol
);

  localparam int SW = DW + FRAC + 3;

  localparam logic signed [DW:0]   OFS  = (DW+1)'(2**(DW-1));
  localparam logic signed [SW-1:0] KRV  = SW'(1436);
  localparam logic signed [SW-1:0] KGU  = SW'(352);
  localparam logic signed [SW-1:0] KGV  = SW'(731);
  localparam logic signed [SW-1:0] KBU  = SW'(1815);
  localparam logic signed [SW-1:0] RND  = SW'(2**(FRAC-1));
  localparam logic signed [SW-1:0] MAXV = SW'(2**DW - 1);

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  logic signed [DW:0]   u;
  logic signed [DW:0]   v;
  logic signed [SW-1:0] u_x;
  logic signed [SW-1:0] v_x;
  logic signed [SW-1:0] y_x;

  assign u   = $signed({1'b0, din1}) - OFS;
  assign v   = $signed({1'b0, din2}) - OFS;
  assign u_x = {{(SW-DW-1){u[DW]}}, u};
  assign v_x = {{(SW-DW-1){v[DW]}}, v};
  assign y_x = {{(SW-DW-FRAC){1'b0}}, din0, {FRAC{1'b0}}};

  logic                 s1_valid, s1_sof, s1_eol;
  logic signed [SW-1:0] s1_y, s1_rv, s1_gu, s1_gv, s1_bu;
  logic                 s2_valid, s2_sof, s2_eol;
  logic signed [SW-1:0] s2_r, s2_g, s2_b;

  // Floor-shift back to integer, then saturate to the unsigned output range.
  function automatic logic [DW-1:0] clip(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] q;
    q = s >>> FRAC;
    if (q[SW-1])
      return '0;
    else if (q > MAXV)
      return '1;
    else
      return q[DW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      dout0     <= '0;
      dout1     <= '0;
      dout2     <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      out_sof   <= s2_sof;
      out_eol   <= s2_eol;
      dout0     <= clip(s2_r);
      dout1     <= clip(s2_g);
      dout2     <= clip(s2_b);
    end
  end

  // Datapath payload needs no reset: it is qualified by the stage valid bits.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_y   <= y_x;
      s1_rv  <= KRV * v_x;
      s1_gu  <= KGU * u_x;
      s1_gv  <= KGV * v_x;
      s1_bu  <= KBU * u_x;
      s1_sof <= in_sof;
      s1_eol <= in_eol;
      s2_r   <= s1_y + s1_rv + RND;
      s2_g   <= s1_y - s1_gu - s1_gv + RND;
      s2_b   <= s1_y + s1_bu + RND;
      s2_sof <= s1_sof;
      s2_eol <= s1_eol;
    end
  end

endmodule

// File: tb/tb_colorspace_inv.sv
// tb/tb_colorspace_inv.sv - self-checking bench for colorspace_inv
// Scoreboard against an integer-arithmetic reference model plus directed latency/clip/reset cases.
module tb_colorspace_inv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sof, in_eol;
  logic [11:0] din0, din1, din2;
  logic        out_valid, out_ready, out_sof, out_eol;
  logic [11:0] dout0, dout1, dout2;

  always #5 clk = ~clk;

  colorspace_inv dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .din2(din2),
    .in_sof(in_sof), .in_eol(in_eol),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout0(dout0), .dout1(dout1), .dout2(dout2),
    .out_sof(out_sof), .out_eol(out_eol)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int emits    = 0;
  int first_emit, last_emit;

  logic [37:0] q[$];
  logic        hold_chk = 1'b0;
  logic [37:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] clip12(input int x);
    if (x < 0) return 12'd0;
    if (x > 4095) return 12'd4095;
    return 12'(x);
  endfunction

  function automatic logic [35:0] model(input int y, input int cb, input int cr);
    int u, v, r, g, b;
    u = cb - 2048;
    v = cr - 2048;
    r = (y * 1024 + 1436 * v + 512) >>> 10;
    g = (y * 1024 - 352 * u - 731 * v + 512) >>> 10;
    b = (y * 1024 + 1815 * u + 512) >>> 10;
    return {clip12(r), clip12(g), clip12(b)};
  endfunction

  function automatic logic [11:0] rnd12();
    case ($urandom % 4)
      0: return 12'd0;
      1: return 12'd4095;
      default: return 12'($urandom);
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hold_chk) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'({out_sof, out_eol, dout0, dout1, dout2}), 64'(held));
    end
    if (rst) begin
      q.delete();
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        emits++;
        if (emits == 1) first_emit = cyc;
        last_emit = cyc;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_beat: got 0x%0h expected no beat (cycle %0d)",
                   {out_sof, out_eol, dout0, dout1, dout2}, cyc);
        end else begin
          chk("pixel", 64'({out_sof, out_eol, dout0, dout1, dout2}), 64'(q.pop_front()));
        end
      end
      if (in_valid && in_ready)
        q.push_back({in_sof, in_eol, model(din0, din1, din2)});
    end
    hold_chk = !rst && out_valid && !out_ready;
    held     = {out_sof, out_eol, dout0, dout1, dout2};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string nm, input logic [11:0] y, input logic [11:0] cb,
                          input logic [11:0] cr, input logic [35:0] exp);
    int n;
    in_valid = 1'b1;
    din0 = y; din1 = cb; din2 = cr;
    in_sof = 1'b1; in_eol = 1'b1;
    n = 0;
    do begin
      tick();
      in_valid = 1'b0;
      in_sof = 1'b0; in_eol = 1'b0;
      n++;
    end while (!out_valid && n < 20);
    chk({nm, "_latency"}, 64'(n), 64'd3);
    chk({nm, "_rgb"}, 64'({dout0, dout1, dout2}), 64'(exp));
    chk({nm, "_sideband"}, 64'({out_sof, out_eol}), 64'd3);
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    din0 = '0; din1 = '0; din2 = '0; in_sof = 1'b0; in_eol = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({out_sof, out_eol, dout0, dout1, dout2}), 64'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    chk("model_mid", 64'(model(2048, 2048, 2048)), 64'({12'd2048, 12'd2048, 12'd2048}));
    chk("model_negclip", 64'(model(0, 2048, 4095)), 64'({12'd2871, 12'd0, 12'd0}));
    chk("model_posclip", 64'(model(4095, 4095, 2048)), 64'({12'd4095, 12'd3391, 12'd4095}));

    directed("mid", 12'd2048, 12'd2048, 12'd2048, {12'd2048, 12'd2048, 12'd2048});
    directed("negclip", 12'd0, 12'd2048, 12'd4095, {12'd2871, 12'd0, 12'd0});
    directed("posclip", 12'd4095, 12'd4095, 12'd2048, {12'd4095, 12'd3391, 12'd4095});

    // Full-rate streaming
    emits = 0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      din0 = rnd12(); din1 = rnd12(); din2 = rnd12();
      in_sof = (i == 0);
      in_eol = (i % 8 == 7);
      tick();
    end
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    repeat (6) tick();
    chk("stream_count", 64'(emits), 64'd64);
    chk("stream_span", 64'(last_emit - first_emit), 64'd63);

    // Random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 2) == 1;
      out_ready = ($urandom % 2) == 1;
      din0 = rnd12(); din1 = rnd12(); din2 = rnd12();
      in_sof = ($urandom % 16) == 0;
      in_eol = ($urandom % 8) == 0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    tick();
    chk("drain_empty", 64'(q.size()), 64'd0);

    // Reset with three beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      din0 = rnd12(); din1 = rnd12(); din2 = rnd12();
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    emits = 0;
    repeat (5) tick();
    chk("rst_no_emerge", 64'(emits), 64'd0);
    directed("post_rst", 12'd1000, 12'd3000, 12'd500, model(1000, 3000, 500));
    tick();
    chk("post_rst_count", 64'(emits), 64'd1);
    chk("post_rst_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
